// File: rtl/ballot_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : ballot_unit_if
//  Purpose  : Vote bus between the voter console (master) and the vote
//             counter (slave). One vote is one cycle of vote_enable with
//             the candidate code on vote_input.
//  Signals  : vote_input  [1:0]  candidate code A=00 B=01 C=10, 11 when idle
//             vote_enable        single-cycle vote strobe
//  Revision : 1.0  initial release
// ============================================================================
interface ballot_unit_if;
    logic [1:0] vote_input;
    logic       vote_enable;

    modport master (output vote_input, output vote_enable);
    modport slave  (input  vote_input, input  vote_enable);
endinterface
`default_nettype wire

// File: rtl/ballot_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ballot_unit
//  Purpose  : Voter-side console. The presiding officer arms one ballot,
//             three candidate buttons are debounced, and exactly one vote
//             strobe is issued per arm. The unit then locks until every
//             button is released. Counts ballots issued (saturating).
//  Ports    : clk, reset (async, active-high)
//             arm                 officer pulse, sampled in IDLE only
//             btn_a/btn_b/btn_c   candidate buttons, already synchronised
//             vote (master)       vote_input / vote_enable bus
//             ready               ballot open and awaiting a press
//             ballots_cast [7:0]  votes issued since reset, holds at 255
//             timeout_flag        one-cycle pulse when an armed ballot expires
//  Options  : BALLOT_TIMEOUT_EN  enables ballot expiry after TIMEOUT_CYCLES;
//             without it the ballot waits forever and timeout_flag is 0.
//  Revision : 1.0  initial release
// ============================================================================
module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4
`ifdef BALLOT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1000
`endif
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          arm,
    input  wire logic          btn_a,
    input  wire logic          btn_b,
    input  wire logic          btn_c,
    ballot_unit_if.master      vote,
    output logic               ready,
    output logic [7:0]         ballots_cast,
    output logic               timeout_flag
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_DEBOUNCE = 3'd2,
        S_EMIT     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t           state;
    logic [2:0]       buttons;
    logic [2:0]       choice;
    logic [DEB_W-1:0] deb_cnt;
    logic             one_hot;
    logic             same_pattern;
    logic             emit_due;
    logic [1:0]       choice_code;

    assign buttons      = {btn_c, btn_b, btn_a};
    assign one_hot      = (buttons == 3'b001) || (buttons == 3'b010) || (buttons == 3'b100);
    assign same_pattern = (buttons == choice);
    // The press has been stable for DEBOUNCE_CYCLES samples and is still held.
    assign emit_due     = (state == S_DEBOUNCE) && same_pattern
                          && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES));

    always_comb begin
        choice_code = 2'b11;
        case (choice)
            3'b001:  choice_code = 2'b00;
            3'b010:  choice_code = 2'b01;
            3'b100:  choice_code = 2'b10;
            default: choice_code = 2'b11;
        endcase
    end

`ifdef BALLOT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_due;
    assign tmo_due = ((state == S_ARMED) || (state == S_DEBOUNCE))
                     && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            choice           <= 3'b000;
            deb_cnt          <= '0;
            vote.vote_input  <= 2'b11;
            vote.vote_enable <= 1'b0;
            ready            <= 1'b0;
            ballots_cast     <= 8'd0;
`ifdef BALLOT_TIMEOUT_EN
            tmo_cnt          <= '0;
            timeout_flag     <= 1'b0;
`endif
        end else begin
            // Strobe and code are only ever presented together for one cycle.
            vote.vote_enable <= 1'b0;
            vote.vote_input  <= 2'b11;
`ifdef BALLOT_TIMEOUT_EN
            timeout_flag     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (arm) begin
                        state   <= S_ARMED;
                        ready   <= 1'b1;
                        deb_cnt <= '0;
`ifdef BALLOT_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (one_hot) begin
                        choice  <= buttons;
                        deb_cnt <= DEB_W'(1);
                        state   <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (emit_due) begin
                        state            <= S_EMIT;
                        ready            <= 1'b0;
                        deb_cnt          <= '0;
                        vote.vote_enable <= 1'b1;
                        vote.vote_input  <= choice_code;
                        if (ballots_cast != 8'hFF)
                            ballots_cast <= ballots_cast + 8'd1;
                    end else if (same_pattern) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end else begin
                        // Release, different button or extra button: start over.
                        deb_cnt <= '0;
                        state   <= S_ARMED;
                    end
                end
                S_EMIT: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (buttons == 3'b000)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
`ifdef BALLOT_TIMEOUT_EN
            // Expiry overrides any ARMED/DEBOUNCE transition except a vote.
            if ((state == S_ARMED) || (state == S_DEBOUNCE)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_due && !emit_due) begin
                    state        <= S_IDLE;
                    ready        <= 1'b0;
                    deb_cnt      <= '0;
                    timeout_flag <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ballot_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ballot_unit
//  Purpose  : Self-checking bench for ballot_unit. A run-length model of the
//             ballot rules predicts every output each cycle; directed
//             scenarios add hand-computed latency/code/count expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ballot_unit;

    localparam int D = 4;
`ifdef BALLOT_TIMEOUT_EN
    localparam int T = 20;
    localparam int MULTI_HOLD = 12;
`else
    localparam int MULTI_HOLD = 20;
`endif

    logic clk = 1'b0;
    logic reset, arm, btn_a, btn_b, btn_c;
    logic ready, timeout_flag;
    logic [7:0] ballots_cast;

    ballot_unit_if vote_bus ();

`ifdef BALLOT_TIMEOUT_EN
    ballot_unit #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
`else
    ballot_unit #(.DEBOUNCE_CYCLES(D)) dut (
`endif
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .btn_a        (btn_a),
        .btn_b        (btn_b),
        .btn_c        (btn_c),
        .vote         (vote_bus.master),
        .ready        (ready),
        .ballots_cast (ballots_cast),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A ballot is "open" from arm until a vote or expiry. A vote happens when
    // the same one-hot pattern has been seen on D+1 consecutive edges of the
    // open ballot. After a vote one cycle passes, then the unit waits for all
    // buttons to be released before it listens to arm again.
    function automatic bit is_one_hot(input logic [2:0] b);
        return (b == 3'b001) || (b == 3'b010) || (b == 3'b100);
    endfunction

    function automatic logic [1:0] code_of(input logic [2:0] b);
        if (b == 3'b001) return 2'b00;
        if (b == 3'b010) return 2'b01;
        return 2'b10;
    endfunction

    bit         m_open, m_emit, m_release;
    int         m_run, m_age;
    logic [2:0] m_pat;
    logic       e_ven, e_ready, e_tmo;
    logic [1:0] e_vin;
    int         e_cnt;

    always @(posedge clk or posedge reset) begin
        logic [2:0] b;
        bit vote;
        if (reset) begin
            m_open = 0; m_emit = 0; m_release = 0; m_run = 0; m_age = 0; m_pat = 3'b000;
            e_ven = 0; e_vin = 2'b11; e_ready = 0; e_tmo = 0; e_cnt = 0;
        end else begin
            b = {btn_c, btn_b, btn_a};
            e_ven = 0; e_vin = 2'b11; e_tmo = 0; vote = 0;
            if (m_open) begin
                if (m_run == 0) begin
                    if (is_one_hot(b)) begin m_run = 1; m_pat = b; end
                end else if (b == m_pat) begin
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (m_run == D + 1) begin
                    vote = 1; e_ven = 1; e_vin = code_of(m_pat);
                    if (e_cnt < 255) e_cnt++;
                    m_open = 0; m_emit = 1; m_run = 0;
                end
`ifdef BALLOT_TIMEOUT_EN
                m_age++;
                if (!vote && m_age == T) begin m_open = 0; e_tmo = 1; m_run = 0; end
`endif
            end else if (m_emit) begin
                m_emit = 0; m_release = 1;
            end else if (m_release) begin
                if (b == 3'b000) m_release = 0;
            end else if (arm) begin
                m_open = 1; m_run = 0; m_age = 0;
            end
            e_ready = m_open;
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("vote_enable",  vote_bus.vote_enable, e_ven);
            chk("vote_input",   vote_bus.vote_input,  e_vin);
            chk("ready",        ready,                e_ready);
            chk("ballots_cast", ballots_cast,         e_cnt);
            chk("timeout_flag", timeout_flag,         e_tmo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_btn(input logic [2:0] p);
        {btn_c, btn_b, btn_a} = p;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Watches n cycles: index of the first strobe (-1 if none), strobe count, code seen.
    task automatic run(input int n, output int first, output int pulses, output logic [1:0] code);
        first = -1; pulses = 0; code = 2'b11;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (vote_bus.vote_enable) begin
                pulses++;
                if (first < 0) begin first = i; code = vote_bus.vote_input; end
            end
        end
    endtask

    task automatic release_all();
        drive_btn(3'b000);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int first, pulses;
        logic [1:0] code;
        reset = 1'b1; arm = 1'b0; drive_btn(3'b000);
        repeat (2) @(negedge clk);
        chk("reset vote_input",  vote_bus.vote_input,  2'b11);
        chk("reset vote_enable", vote_bus.vote_enable, 1'b0);
        chk("reset ready",       ready,                1'b0);
        chk("reset ballots",     ballots_cast,         8'd0);
        chk("reset timeout",     timeout_flag,         1'b0);
        reset = 1'b0;
        started = 1'b1;
        @(negedge clk);

        // 1: clean press of B held 10 cycles
        do_arm();
        chk("t1 ready after arm", ready, 1'b1);
        drive_btn(3'b010);
        run(10, first, pulses, code);
        chk("t1 latency", first, D + 1);
        chk("t1 pulses", pulses, 1);
        chk("t1 code", code, 2'b01);
        chk("t1 ballots", ballots_cast, 8'd1);
        release_all();

        // 2: bouncing A
        do_arm();
        drive_btn(3'b001); @(negedge clk);
        drive_btn(3'b000); @(negedge clk);
        drive_btn(3'b001);
        run(10, first, pulses, code);
        chk("t2 latency", first, D + 1);
        chk("t2 pulses", pulses, 1);
        chk("t2 code", code, 2'b00);
        release_all();

        // 3: A+C together, then A released
        do_arm();
        drive_btn(3'b101);
        run(MULTI_HOLD, first, pulses, code);
        chk("t3 multi pulses", pulses, 0);
        chk("t3 multi ready", ready, 1'b1);
        drive_btn(3'b100);
        run(10, first, pulses, code);
        chk("t3 latency", first, D + 1);
        chk("t3 code", code, 2'b10);
        chk("t3 ballots", ballots_cast, 8'd3);

        // 4: arm while still holding C after the vote
        do_arm();
        run(5, first, pulses, code);
        chk("t4 held pulses", pulses, 0);
        chk("t4 held ready", ready, 1'b0);
        release_all();
        do_arm();
        drive_btn(3'b001);
        run(8, first, pulses, code);
        chk("t4 second latency", first, D + 1);
        chk("t4 ballots", ballots_cast, 8'd4);
        release_all();
        for (int k = 0; k < 251; k++) begin
            do_arm();
            drive_btn(3'b010);
            run(7, first, pulses, code);
            release_all();
        end
        chk("t4 ballots at 255", ballots_cast, 8'd255);
        do_arm();
        drive_btn(3'b100);
        run(7, first, pulses, code);
        chk("t4 256th pulses", pulses, 1);
        chk("t4 saturate", ballots_cast, 8'd255);
        release_all();

        // 5: reset in the middle of debounce
        do_arm();
        drive_btn(3'b001);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5 vote_enable", vote_bus.vote_enable, 1'b0);
        chk("t5 vote_input",  vote_bus.vote_input,  2'b11);
        chk("t5 ready",       ready,                1'b0);
        chk("t5 ballots",     ballots_cast,         8'd0);
        chk("t5 timeout",     timeout_flag,         1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(8, first, pulses, code);
        chk("t5 no vote after reset", pulses, 0);
        release_all();

`ifdef BALLOT_TIMEOUT_EN
        // 6: armed ballot expires
        begin
            int tfirst;
            tfirst = -1;
            do_arm();
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (timeout_flag && tfirst < 0) tfirst = i;
            end
            chk("t6 timeout latency", tfirst, T);
            chk("t6 ready", ready, 1'b0);
            chk("t6 ballots", ballots_cast, 8'd0);
            do_arm();
            drive_btn(3'b010);
            run(8, first, pulses, code);
            chk("t6 vote after expiry", first, D + 1);
            release_all();
        end
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
